// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV64 instruction encoder with a 2-entry output FIFO.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);
    localparam logic [3:0] OP_ADDI  = 4'd0;
    localparam logic [3:0] OP_SLTI  = 4'd1;
    localparam logic [3:0] OP_SLTIU = 4'd2;
    localparam logic [3:0] OP_XORI  = 4'd3;
    localparam logic [3:0] OP_ORI   = 4'd4;
    localparam logic [3:0] OP_ANDI  = 4'd5;
    localparam logic [3:0] OP_SLLI  = 4'd6;
    localparam logic [3:0] OP_SRLI  = 4'd7;
    localparam logic [3:0] OP_SRAI  = 4'd8;
    localparam logic [3:0] OP_LD    = 4'd9;
    localparam logic [3:0] OP_JALR  = 4'd10;
    localparam logic [3:0] OP_SD    = 4'd11;
    localparam logic [3:0] OP_LUI   = 4'd12;
    localparam logic [3:0] OP_AUIPC = 4'd13;
    localparam logic [3:0] OP_JAL   = 4'd14;

    localparam logic [6:0] OPC_IMM = 7'b0010011;

    logic [31:0] enc_instr;
    logic        enc_bad_op;
    logic        enc_err;

    logic [31:0] mem_instr [2];
    logic        mem_err   [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    always_comb begin
        enc_instr  = 32'h0000_0013;
        enc_bad_op = 1'b0;
        case (in_op)
            OP_ADDI:  enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_IMM};
            OP_SLTI:  enc_instr = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_IMM};
            OP_SLTIU: enc_instr = {in_imm[11:0], in_rs1, 3'b011, in_rd, OPC_IMM};
            OP_XORI:  enc_instr = {in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_IMM};
            OP_ORI:   enc_instr = {in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_IMM};
            OP_ANDI:  enc_instr = {in_imm[11:0], in_rs1, 3'b111, in_rd, OPC_IMM};
            OP_SLLI:  enc_instr = {6'b000000, in_imm[5:0], in_rs1, 3'b001, in_rd, OPC_IMM};
            OP_SRLI:  enc_instr = {6'b000000, in_imm[5:0], in_rs1, 3'b101, in_rd, OPC_IMM};
            OP_SRAI:  enc_instr = {6'b010000, in_imm[5:0], in_rs1, 3'b101, in_rd, OPC_IMM};
            OP_LD:    enc_instr = {in_imm[11:0], in_rs1, 3'b011, in_rd, 7'b0000011};
            OP_JALR:  enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            OP_SD:    enc_instr = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], 7'b0100011};
            OP_LUI:   enc_instr = {in_imm[31:12], in_rd, 7'b0110111};
            OP_AUIPC: enc_instr = {in_imm[31:12], in_rd, 7'b0010111};
            OP_JAL:   enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                   in_rd, 7'b1101111};
            default:  enc_bad_op = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // True when in_imm is a sign extension of its low (msb+1) bits.
    function automatic logic fits_signed(input logic [63:0] v, input int msb);
        logic [63:0] hi;
        hi = 64'($signed(v) >>> msb);
        return (hi == 64'd0) || (hi == {64{1'b1}});
    endfunction

    logic imm_bad;

    always_comb begin
        imm_bad = 1'b0;
        case (in_op)
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
            OP_LD, OP_JALR, OP_SD:   imm_bad = !fits_signed(in_imm, 11);
            OP_SLLI, OP_SRLI, OP_SRAI: imm_bad = |in_imm[63:6];
            OP_LUI, OP_AUIPC:        imm_bad = (|in_imm[11:0]) || !fits_signed(in_imm, 31);
            OP_JAL:                  imm_bad = in_imm[0] || !fits_signed(in_imm, 20);
            default:                 imm_bad = 1'b0;
        endcase
    end

    assign enc_err = enc_bad_op | imm_bad;
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[63:32];
    assign enc_err       = enc_bad_op;
`endif

    // No pass-through: a full FIFO refuses input even while it is being drained.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'd0;
    assign out_err   = out_valid ? mem_err[rd_ptr]   : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            mem_instr[0] <= 32'd0;
            mem_instr[1] <= 32'd0;
            mem_err[0]   <= 1'b0;
            mem_err[1]   <= 1'b0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= enc_instr;
                mem_err[wr_ptr]   <= enc_err;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with a field-level reference model.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [63:0] in_imm = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb [$];

    instr_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: opcode/funct3/format table, instruction assembled with shifts and masks.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [63:0] imm);
        longint unsigned opc, f3, w, u;
        longint s;
        int fmt;
        logic bad;
        u = imm;
        s = $signed(imm);
        bad = 1'b0;
        fmt = 5;
        opc = 0;
        f3 = 0;
        case (op)
            0:  begin fmt = 0; opc = 7'h13; f3 = 0; end
            1:  begin fmt = 0; opc = 7'h13; f3 = 2; end
            2:  begin fmt = 0; opc = 7'h13; f3 = 3; end
            3:  begin fmt = 0; opc = 7'h13; f3 = 4; end
            4:  begin fmt = 0; opc = 7'h13; f3 = 6; end
            5:  begin fmt = 0; opc = 7'h13; f3 = 7; end
            6:  begin fmt = 1; opc = 7'h13; f3 = 1; end
            7:  begin fmt = 1; opc = 7'h13; f3 = 5; end
            8:  begin fmt = 1; opc = 7'h13; f3 = 5; end
            9:  begin fmt = 0; opc = 7'h03; f3 = 3; end
            10: begin fmt = 0; opc = 7'h67; f3 = 0; end
            11: begin fmt = 2; opc = 7'h23; f3 = 3; end
            12: begin fmt = 3; opc = 7'h37; end
            13: begin fmt = 3; opc = 7'h17; end
            14: begin fmt = 4; opc = 7'h6F; end
            default: fmt = 5;
        endcase
        case (fmt)
            0: begin
                w = ((u % 4096) << 20) | (64'(rs1) << 15) | (f3 << 12) | (64'(rd) << 7) | opc;
                bad = (s < -2048) || (s > 2047);
            end
            1: begin
                w = ((u % 64) << 20) | (64'(rs1) << 15) | (f3 << 12) | (64'(rd) << 7) | opc;
                if (op == 8) w = w | (64'h10 << 26);
                bad = (u > 63);
            end
            2: begin
                w = (((u >> 5) % 128) << 25) | (64'(rs2) << 20) | (64'(rs1) << 15) |
                    (f3 << 12) | ((u % 32) << 7) | opc;
                bad = (s < -2048) || (s > 2047);
            end
            3: begin
                w = (((u >> 12) % (1 << 20)) << 12) | (64'(rd) << 7) | opc;
                bad = ((u % 4096) != 0) || (s < -(64'sd1 << 31)) || (s > (64'sd1 << 31) - 1);
            end
            4: begin
                w = (((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21) |
                    (((u >> 11) % 2) << 20) | (((u >> 12) % 256) << 12) | (64'(rd) << 7) | opc;
                bad = ((u % 2) != 0) || (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1);
            end
            default: w = 64'h13;
        endcase
`ifndef ENCODER_RANGE_CHECK_EN
        bad = 1'b0;
`endif
        return {w[31:0], (fmt == 5) || bad};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [63:0] imm);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_exp(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [63:0] imm,
                            input logic [32:0] exp, input bit rnd_ready);
        int n;
        n = 0;
        drive(op, rd, rs1, rs2, imm);
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 expected 1");
        end else begin
            sb.push_back(exp);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] imm, input bit rnd_ready);
        send_exp(op, rd, rs1, rs2, imm, model(op, rd, rs1, rs2, imm), rnd_ready);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] rand_imm();
        case ($urandom_range(0, 3))
            0: return 64'($signed($urandom_range(0, 6000)) - 3000);
            1: return {$urandom, $urandom};
            2: return 64'($urandom_range(0, 70));
            default: return 64'($signed({$urandom, $urandom}) >>> 32) & ~64'hFFF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got 0x%0h expected none", out_instr);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("out_instr", 64'(out_instr), 64'(e[32:1]));
                check("out_err", 64'(out_err), 64'(e[0]));
            end
        end
    end

    initial begin
        logic [32:0] e3;
        logic exp_range_err;
`ifdef ENCODER_RANGE_CHECK_EN
        exp_range_err = 1'b1;
`else
        exp_range_err = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Known encodings, with first-result latency of one edge.
        out_ready = 1'b1;
        drive(4'd0, 5'd1, 5'd2, 5'd0, -64'sd1);
        sb.push_back({32'hFFF10093, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency_valid", 64'(out_valid), 64'd1);
        send_exp(4'd12, 5'd5, 5'd0, 5'd0, 64'h1234_5000, {32'h123452B7, 1'b0}, 1'b0);
        send_exp(4'd11, 5'd0, 5'd2, 5'd3, 64'd8, {32'h00313423, 1'b0}, 1'b0);
        send_exp(4'd14, 5'd1, 5'd0, 5'd0, 64'd8, {32'h008000EF, 1'b0}, 1'b0);
        send_exp(4'd8, 5'd1, 5'd1, 5'd0, 64'd63, {32'h43F0D093, 1'b0}, 1'b0);
        send_exp(4'd0, 5'd1, 5'd2, 5'd0, 64'd2048, {32'h80010093, exp_range_err}, 1'b0);
        send_exp(4'd15, 5'd7, 5'd8, 5'd9, 64'd5, {32'h00000013, 1'b1}, 1'b0);
        drain();

        // Backpressure: third request held until the FIFO frees a slot.
        out_ready = 1'b0;
        send(4'd3, 5'd3, 5'd4, 5'd0, 64'd100, 1'b0);
        send(4'd5, 5'd6, 5'd7, 5'd0, -64'sd7, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        e3 = model(4'd9, 5'd10, 5'd11, 5'd0, 64'd16);
        drive(4'd9, 5'd10, 5'd11, 5'd0, 64'd16);
        repeat (2) @(posedge clk);
        #1;
        check("held_in_ready", 64'(in_ready), 64'd0);
        check("held_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("freed_in_ready", 64'(in_ready), 64'd1);
        sb.push_back(e3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset with two entries pending discards them immediately.
        out_ready = 1'b0;
        send(4'd1, 5'd1, 5'd1, 5'd0, 64'd1, 1'b0);
        send(4'd2, 5'd2, 5'd2, 5'd0, 64'd2, 1'b0);
        reset = 1'b0;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_out_instr", 64'(out_instr), 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd13, 5'd4, 5'd0, 5'd0, 64'hABCDE000, 1'b0);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        drain();

        // Randomized traffic with random consumer stalls.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                     rand_imm(), 1'b1);
            end else begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
